// File: rtl/cache_burst_controller.sv
// Cache line burst controller. It sequences hit service, dirty write-back, line refill and the
// write-through store, with one beat counter shared by both bursts.
module cache_burst_controller #(
  parameter int BEATS         = 4,
  parameter int WRITE_THROUGH = 0,
  parameter int CW            = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          req_type,
  input  logic          hit,
  input  logic          dirty_bit,
  input  logic          ready_mem,
  input  logic          valid_mem,
  output logic          valid_cache,
  output logic          ready_cache,
  output logic          read_en_mem,
  output logic          write_en_mem,
  output logic          read_en_cache,
  output logic          write_en_cache,
  output logic          refill,
  output logic          done_cache,
  output logic [CW-1:0] beat_idx,
  output logic          busy,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    COMPARE        = 3'd1,
    WRITE_BACK     = 3'd2,
    WRITE_ALLOCATE = 3'd3,
    REFILL_DONE    = 3'd4,
    WT_WRITE       = 3'd5
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam bit            WT   = (WRITE_THROUGH != 0);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          req_type_q;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Handshake: a write-back beat moves on each cycle with ready_mem high in WRITE_BACK, and a
  // refill beat on each cycle with valid_mem high in WRITE_ALLOCATE. The strobes are registered,
  // so they describe the transfer decided in the previous cycle's state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      req_type_q     <= 1'b0;
      valid_cache    <= 1'b0;
      ready_cache    <= 1'b0;
      read_en_mem    <= 1'b0;
      write_en_mem   <= 1'b0;
      read_en_cache  <= 1'b0;
      write_en_cache <= 1'b0;
      refill         <= 1'b0;
      done_cache     <= 1'b0;
      beat_idx       <= '0;
    end else begin
      valid_cache    <= 1'b0;
      ready_cache    <= 1'b0;
      read_en_mem    <= 1'b0;
      write_en_mem   <= 1'b0;
      read_en_cache  <= 1'b0;
      write_en_cache <= 1'b0;
      refill         <= 1'b0;
      done_cache     <= 1'b0;
      beat_idx       <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_type_q <= req_type;
            state      <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            if (!req_type_q) begin
              read_en_cache <= 1'b1;
              done_cache    <= 1'b1;
              state         <= IDLE;
            end else begin
              write_en_cache <= 1'b1;
              if (WT) begin
                state <= WT_WRITE;
              end else begin
                done_cache <= 1'b1;
                state      <= IDLE;
              end
            end
          end else begin
            cnt   <= '0;
            state <= (dirty_bit && !WT) ? WRITE_BACK : WRITE_ALLOCATE;
          end
        end
        WRITE_BACK: begin
          valid_cache   <= 1'b1;
          read_en_cache <= 1'b1;
          beat_idx      <= cnt;
          write_en_mem  <= ready_mem;
          if (ready_mem) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= WRITE_ALLOCATE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        WRITE_ALLOCATE: begin
          read_en_mem    <= 1'b1;
          ready_cache    <= 1'b1;
          beat_idx       <= cnt;
          write_en_cache <= valid_mem;
          if (valid_mem) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= REFILL_DONE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        REFILL_DONE: begin
          refill         <= 1'b1;
          write_en_cache <= req_type_q;
          read_en_cache  <= ~req_type_q;
          // A write-through store still has to reach memory before the request completes.
          if (WT && req_type_q) begin
            state <= WT_WRITE;
          end else begin
            done_cache <= 1'b1;
            state      <= IDLE;
          end
        end
        WT_WRITE: begin
          valid_cache  <= 1'b1;
          write_en_mem <= ready_mem;
          if (ready_mem) begin
            done_cache <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
